// File: rtl/regfile_read_port.sv
// ============================================================================
//  Module      : regfile_read_port
//  Description : Registered read port for the register file. Selects one of
//                DEPTH entries, forwards a same-cycle write to the selected
//                entry, and presents the result through a valid/ready output
//                stage backed by a one-entry skid register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_read_port #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int SEL_W    = $clog2(DEPTH),
  parameter bit ZERO_REG = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DEPTH*WIDTH-1:0] in_flat,
  input  logic                   rd_valid,
  output logic                   rd_ready,
  input  logic [SEL_W-1:0]       rd_sel,
  input  logic                   wr_en,
  input  logic [SEL_W-1:0]       wr_sel,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [SEL_W-1:0]       out_sel,
  output logic                   out_err
);

  // Every code of rd_sel gets a slot; codes beyond DEPTH read as zero so the
  // lookup index is never out of bounds.
  localparam int c_slots = 1 << SEL_W;

  logic [WIDTH-1:0] entry [c_slots];
  logic             in_range;

  generate
    for (genvar i = 0; i < c_slots; i++) begin : g_entry
      if (i < DEPTH) begin : g_real
        assign entry[i] = in_flat[i*WIDTH +: WIDTH];
      end else begin : g_pad
        assign entry[i] = '0;
      end
    end

    // With a power-of-two DEPTH every select code is a real entry.
    if (DEPTH == c_slots) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_part_range
      localparam logic [SEL_W-1:0] c_depth = SEL_W'(DEPTH);
      assign in_range = (rd_sel < c_depth);
    end
  endgenerate

  // Lookup result for the request presented this cycle.
  logic [WIDTH-1:0] lk_data;
  logic             lk_err;

  // Priority: out-of-range, hard-wired zero entry, write bypass, array.
  always_comb begin
    lk_data = entry[rd_sel];
    lk_err  = 1'b0;
    if (!in_range) begin
      lk_data = '0;
      lk_err  = 1'b1;
    end else if (ZERO_REG && (rd_sel == '0)) begin
      lk_data = '0;
    end else if (wr_en && (wr_sel == rd_sel)) begin
      lk_data = wr_data;
    end
  end

  // Output stage state: main register drives the outputs, skid catches one
  // extra result while main is stalled.
  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q,  main_data_d;
  logic [SEL_W-1:0] main_sel_q,   main_sel_d;
  logic             main_err_q,   main_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic [SEL_W-1:0] skid_sel_q,   skid_sel_d;
  logic             skid_err_q,   skid_err_d;
  logic             rd_ready_q,   rd_ready_d;

  logic accept;
  logic fire;

  assign accept = rd_valid && rd_ready_q;
  assign fire   = main_valid_q && out_ready;

  // Next-state of main/skid: drain first, then place any new result.
  // An accept implies the skid is empty, so a refill from skid and a new
  // result never compete for main in the same cycle.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_sel_d   = main_sel_q;
    main_err_d   = main_err_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_sel_d   = skid_sel_q;
    skid_err_d   = skid_err_q;

    if (fire) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_sel_d   = skid_sel_q;
        main_err_d   = skid_err_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b0;
      end
    end

    if (accept) begin
      if (!main_valid_q || fire) begin
        main_valid_d = 1'b1;
        main_data_d  = lk_data;
        main_sel_d   = rd_sel;
        main_err_d   = lk_err;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = lk_data;
        skid_sel_d   = rd_sel;
        skid_err_d   = lk_err;
      end
    end

    // Registered so rd_ready has no combinational path from out_ready.
    rd_ready_d = !skid_valid_d;
  end

  // Output stage registers; reset drops every queued result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_sel_q   <= '0;
      main_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_sel_q   <= '0;
      skid_err_q   <= 1'b0;
      rd_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_sel_q   <= main_sel_d;
      main_err_q   <= main_err_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sel_q   <= skid_sel_d;
      skid_err_q   <= skid_err_d;
      rd_ready_q   <= rd_ready_d;
    end
  end

  assign rd_ready  = rd_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;
  assign out_err   = main_err_q;

endmodule

`default_nettype wire
